// File: rtl/barrett_reduce_pipe.sv
// barrett_reduce_pipe: three-stage pipelined Barrett reducer, dout_r = din_a mod Q.
// One operand per cycle over valid/ready, fixed 3-cycle latency, global stall on backpressure.
// Optional macro BARRETT_TAG_EN adds an in_tag/out_tag sideband that rides along with each operand.

module barrett_reduce_pipe #(
  parameter int unsigned Q  = 3923,
  parameter int unsigned QW = 12,
  parameter int unsigned DW = 2*QW-1
`ifdef BARRETT_TAG_EN
  ,
  parameter int unsigned TAG_W = 8
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] din_a,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] dout_r
`ifdef BARRETT_TAG_EN
  ,
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] out_tag
`endif
);

  localparam int unsigned K   = 2*QW;
  localparam int unsigned PW  = DW + K + 1;
  localparam int unsigned QEW = DW + 1;
  localparam int unsigned RW  = QW + 2;

  // Barrett constant floor(2^K / Q), evaluated at elaboration.
  function automatic logic [K:0] calc_m();
    logic [K:0] num;
    num = (K+1)'(1) << K;
    return num / (K+1)'(Q);
  endfunction

  localparam logic [K:0] M = calc_m();

  // Reject moduli that do not fit the result width, or operands too wide for the shift.
  if ((64'(Q) >= (64'(1) << QW)) || (DW > 2*QW)) begin : g_param_err
    $error("barrett_reduce_pipe: illegal parameters Q=%0d QW=%0d DW=%0d", Q, QW, DW);
  end

  logic          adv;
  logic          v1;
  logic [DW-1:0] x1;
  logic [PW-1:0] p1;
  logic          v2;
  logic [RW-1:0] r2;
  logic [QEW-1:0] qe_c;
  logic [RW-1:0]  rem_c;
  logic [RW-1:0]  r_a_c;
  logic [RW-1:0]  r_b_c;

  // Whole pipeline moves together whenever the output slot is free or being drained.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1: capture operand and its product with the Barrett constant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      x1 <= '0;
      p1 <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      x1 <= din_a;
      p1 <= PW'(din_a) * PW'(M);
    end
  end

  // Quotient estimate and coarse remainder; modular QW+2 arithmetic is exact since r < 3Q.
  always_comb begin
    qe_c  = QEW'(p1 >> K);
    rem_c = RW'(x1) - (RW'(qe_c) * RW'(Q));
  end

  // Stage 2: register the coarse remainder.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      r2 <= '0;
    end else if (adv) begin
      v2 <= v1;
      r2 <= rem_c;
    end
  end

  // Two sequential conditional subtractions bring the remainder into [0, Q).
  always_comb begin
    r_a_c = (r2 >= RW'(Q)) ? (r2 - RW'(Q)) : r2;
    r_b_c = (r_a_c >= RW'(Q)) ? (r_a_c - RW'(Q)) : r_a_c;
  end

  // Stage 3: output register, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dout_r    <= '0;
    end else if (adv) begin
      out_valid <= v2;
      dout_r    <= QW'(r_b_c);
    end
  end

`ifdef BARRETT_TAG_EN
  logic [TAG_W-1:0] t1;
  logic [TAG_W-1:0] t2;

  // Tag sideband follows its operand with identical stall behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t1      <= '0;
      t2      <= '0;
      out_tag <= '0;
    end else if (adv) begin
      t1      <= in_tag;
      t2      <= t1;
      out_tag <= t2;
    end
  end
`endif

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Directed bench for barrett_reduce_pipe: defaults (Q=3923) and a second set (Q=7681, QW=13, DW=25).

module tb_barrett_reduce_pipe;

  localparam int unsigned DW1 = 23;
  localparam int unsigned QW1 = 12;
  localparam int unsigned DW2 = 25;
  localparam int unsigned QW2 = 13;

  logic clk;
  logic rst_n;

  logic           in_valid;
  logic           in_ready;
  logic [DW1-1:0] din_a;
  logic           out_valid;
  logic           out_ready;
  logic [QW1-1:0] dout_r;

  logic           in_valid2;
  logic           in_ready2;
  logic [DW2-1:0] din_a2;
  logic           out_valid2;
  logic           out_ready2;
  logic [QW2-1:0] dout_r2;

`ifdef BARRETT_TAG_EN
  logic [7:0] in_tag;
  logic [7:0] out_tag;
  logic [7:0] in_tag2;
  logic [7:0] out_tag2;
`endif

  int n_cmp;
  int n_err;
  int cyc;
  int first_acc;
  int first_emit;

  logic [DW1-1:0] pend_d[$];
  logic [QW1-1:0] pend_e[$];
  logic [QW1-1:0] exp_q[$];
  logic [DW2-1:0] pend2_d[$];
  logic [QW2-1:0] pend2_e[$];
  logic [QW2-1:0] exp2_q[$];
`ifdef BARRETT_TAG_EN
  logic [7:0] tag_cnt;
  logic [7:0] tag_q[$];
`endif

  logic           last_in_ready;
  logic           last_ov;
  logic [QW1-1:0] last_dout;

  barrett_reduce_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din_a     (din_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout_r    (dout_r)
`ifdef BARRETT_TAG_EN
    ,
    .in_tag    (in_tag),
    .out_tag   (out_tag)
`endif
  );

  barrett_reduce_pipe #(.Q(7681), .QW(QW2), .DW(DW2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .din_a     (din_a2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .dout_r    (dout_r2)
`ifdef BARRETT_TAG_EN
    ,
    .in_tag    (in_tag2),
    .out_tag   (out_tag2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One cycle on the default instance: offer next pending operand, check any emitted result.
  task automatic step(input logic rdy);
    in_valid  = (pend_d.size() != 0);
    din_a     = in_valid ? pend_d[0] : '0;
    out_ready = rdy;
`ifdef BARRETT_TAG_EN
    in_tag    = tag_cnt;
`endif
    #1;
    last_in_ready = in_ready;
    last_ov       = out_valid;
    last_dout     = dout_r;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 64'(out_valid), 64'(0));
      end else begin
        chk("result", 64'(dout_r), 64'(exp_q.pop_front()));
`ifdef BARRETT_TAG_EN
        chk("tag", 64'(out_tag), 64'(tag_q.pop_front()));
`endif
        if (first_emit < 0) first_emit = cyc;
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(pend_e.pop_front());
      void'(pend_d.pop_front());
`ifdef BARRETT_TAG_EN
      tag_q.push_back(tag_cnt);
      tag_cnt = tag_cnt + 8'd1;
`endif
      if (first_acc < 0) first_acc = cyc;
    end
    cyc++;
    @(negedge clk);
  endtask

  // One cycle on the second instance.
  task automatic step2(input logic rdy);
    in_valid2  = (pend2_d.size() != 0);
    din_a2     = in_valid2 ? pend2_d[0] : '0;
    out_ready2 = rdy;
    #1;
    if (out_valid2 && out_ready2) begin
      if (exp2_q.size() == 0) chk("spurious_out2", 64'(out_valid2), 64'(0));
      else chk("result2", 64'(dout_r2), 64'(exp2_q.pop_front()));
    end
    if (in_valid2 && in_ready2) begin
      exp2_q.push_back(pend2_e.pop_front());
      void'(pend2_d.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic push1(input logic [DW1-1:0] d, input logic [QW1-1:0] e);
    pend_d.push_back(d);
    pend_e.push_back(e);
  endtask

  task automatic push2(input logic [DW2-1:0] d, input logic [QW2-1:0] e);
    pend2_d.push_back(d);
    pend2_e.push_back(e);
  endtask

  // Run with out_ready=1 until everything is delivered; an expired budget is a failure.
  task automatic drain1(input int budget);
    int n;
    n = 0;
    while ((pend_d.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step(1'b1);
      n++;
    end
    chk("drain1_done", 64'(exp_q.size() + pend_d.size()), 64'(0));
  endtask

  initial begin
    int steps;
    logic [DW2-1:0] rd;
    n_cmp = 0; n_err = 0; cyc = 0;
    first_acc = -1; first_emit = -1;
    rst_n = 1'b0;
    in_valid = 1'b0; din_a = '0; out_ready = 1'b0;
    in_valid2 = 1'b0; din_a2 = '0; out_ready2 = 1'b0;
`ifdef BARRETT_TAG_EN
    tag_cnt = 8'd1; in_tag = '0; in_tag2 = '0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_dout", 64'(dout_r), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid2", 64'(out_valid2), 64'(0));
    @(negedge clk);

    // Full sweep 0..Q-1 back-to-back.
    for (int i = 0; i < 3923; i++) push1(DW1'(i), QW1'(i));
    steps = 0;
    while ((pend_d.size() != 0 || exp_q.size() != 0) && steps < 5000) begin
      step(1'b1);
      steps++;
    end
    chk("sweep_rate", 64'(steps), 64'(3926));
    chk("first_latency", 64'(first_emit - first_acc), 64'(3));

    // Boundaries.
    push1(23'd3923, 12'd0);
    push1(23'd7845, 12'd3922);
    push1(23'd8388607, 12'd1233);
    push1(23'd0, 12'd0);
    push1(23'd3922, 12'd3922);
    drain1(20);

    // Backpressure: six stalled cycles with four operands offered.
    push1(23'd10, 12'd10);
    push1(23'd4000, 12'd77);
    push1(23'd8000, 12'd154);
    push1(23'd3923, 12'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0);
      if (i >= 3) begin
        chk("bp_in_ready", 64'(last_in_ready), 64'(0));
        chk("bp_out_valid", 64'(last_ov), 64'(1));
        chk("bp_hold", 64'(last_dout), 64'(10));
      end
    end
    chk("bp_accepted", 64'(pend_d.size()), 64'(1));
    drain1(20);

    // Reset with two operands in flight.
    push1(23'd100, 12'd100);
    push1(23'd200, 12'd200);
    step(1'b1);
    step(1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_dout", 64'(dout_r), 64'(0));
    exp_q.delete();
`ifdef BARRETT_TAG_EN
    tag_q.delete();
`endif
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      chk("midrst_quiet", 64'(last_ov), 64'(0));
    end

`ifdef BARRETT_TAG_EN
    // Tags 0x01..0x20 with random stalls; result and tag checked in step().
    tag_cnt = 8'd1;
    for (int i = 1; i <= 32; i++) push1(DW1'(i * 1237), QW1'((i * 1237) % 3923));
    steps = 0;
    while ((pend_d.size() != 0 || exp_q.size() != 0) && steps < 500) begin
      step(1'($urandom_range(0, 2) != 0));
      steps++;
    end
    chk("tag_done", 64'(exp_q.size() + pend_d.size()), 64'(0));
`endif

    // Second parameter set: directed, then random against the % reference.
    push2(25'd7681, 13'd0);
    push2(25'd33554431, 13'd3823);
    push2(25'd7680, 13'd7680);
    for (int i = 0; i < 10000; i++) begin
      rd = DW2'($urandom);
      push2(rd, QW2'(rd % 25'd7681));
    end
    steps = 0;
    while ((pend2_d.size() != 0 || exp2_q.size() != 0) && steps < 60000) begin
      step2(1'($urandom_range(0, 3) != 0));
      steps++;
    end
    chk("set2_done", 64'(exp2_q.size() + pend2_d.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
